dispatch: RTL and testbench
===========================

Name: dispatch

Overview:
Dispatch stage of the out-of-order core, between Rename and the three reservation stations (ALU, branch, LSU). It accepts one renamed instruction per cycle into a one-entry skid buffer, then moves it into the reservation station chosen by its FU type. It keeps an internal physical-register ready table and wakes RS operands from three CDB broadcast ports. Each RS issues its oldest operand-ready entry to its functional unit.

Parameters:
ALU_RS_DEPTH, 8, ALU reservation-station entries
BR_RS_DEPTH, 4, branch reservation-station entries
LSU_RS_DEPTH, 8, LSU reservation-station entries
NUM_PREGS, 128, physical registers (7-bit tags)

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  asynchronous, active-low reset
valid_in  in  1  Rename offers an instruction
data_in  in  rename_data  fields: fu_alu, fu_mem, fu_br, OpCode[6:0], rob_tag[4:0], pd_new[6:0], ps1[6:0], ps2[6:0], imm
ready_in  out  1  Dispatch can accept data_in this cycle
alu_rs_valid_out, br_rs_valid_out, lsu_rs_valid_out  out  1 each  issue valid to that FU
alu_rs_data_out, br_rs_data_out, lsu_rs_data_out  out  rs_data  issued entry: rob_index, OpCode, pd, ps1, ps2, imm, FU type
alu_rs_ready_in, br_rs_ready_in, lsu_rs_ready_in  in  1 each  FU accepts an issue
dispatch_nr_reg  out  7  destination preg of the last RS-dispatched instruction
dispatch_nr_valid  out  1  dispatch_nr_reg is meaningful
preg1_rdy, preg2_rdy, preg3_rdy  in  7 each  CDB broadcast tags
preg1_valid, preg2_valid, preg3_valid  in  1 each  CDB tag valid
complete_in  in  1  ROB completion strobe; no effect on dispatch state
rob_fu_tag  in  5  ROB tag of the completion; no effect on dispatch state
mispredict  in  1  branch mispredict flush request
mispredict_tag  in  5  ROB tag of the mispredicted branch
rob_retire_tag  in  5  ROB head tag, used as the age reference
rob_retire_valid  in  1  rob_retire_tag is valid

Behaviour:
- Reset (reset low, asynchronous): skid buffer empty; all RS entries invalid; every *_valid_out = 0; dispatch_nr_valid = 0; dispatch_nr_reg = 0; ready table clears all pregs to not-ready except p0, which is always ready.
- Accept: a transfer occurs when valid_in && ready_in at a clock edge. data_in is latched into the skid buffer.
- Route: the target RS is ALU if fu_alu, LSU if fu_mem, otherwise branch. Exactly one FU bit is expected to be set.
- ready_in (combinational) = (skid buffer empty, or it drains this cycle) AND (valid_in = 0, or the RS targeted by data_in has a free entry after counting the buffered instruction if it targets the same RS).
- Buffer to RS: the buffered instruction is written into a free entry of its RS at the next edge, one cycle after acceptance, if space exists; otherwise it waits in the buffer.
- On the RS write:
  - The entry is written with rob_index = rob_tag.
  - Each source ready bit = ready-table bit of that source OR a same-cycle CDB match. Source 0 is always ready; LSU ps2 = 0 is therefore ready.
  - pd_new is marked not-ready in the ready table.
  - dispatch_nr_reg ← pd_new and dispatch_nr_valid ← 1. These are registered and held until the next RS write or reset.
- Wakeup: each valid CDB port sets its tag ready in the ready table and sets the matching source ready bits in all RS entries at that edge. CDB wins over a same-cycle busy-marking of the same preg.
- Issue:
  - Per RS, combinationally select the oldest valid entry with both sources ready; oldest is by ROB age relative to rob_retire_tag.
  - *_valid_out = 1 with that entry on *_data_out.
  - The entry is freed at the edge where valid && ready_in.
  - An instruction therefore issues no earlier than the cycle after the CDB edge that woke its last source.
- Full: an RS at depth blocks routing to it; other RSs are unaffected unless the skid buffer holds a blocked instruction.
- Mispredict: at the edge, invalidate RS and skid entries whose age ((tag − rob_retire_tag) mod 32) is greater than that of mispredict_tag. The branch itself survives. ready_in = 0 during the mispredict cycle.
- Simultaneous issue and write into the same RS in one cycle is allowed; the freed slot counts as free next cycle only.

Test Plan:
- Reset, then send ALU tag 1, pd 10, ps 1/2 (not ready) → two cycles later dispatch_nr_valid=1, dispatch_nr_reg=10, alu_rs_valid_out=0.
- Broadcast p1 on port 1 and p2 on port 2 for one cycle → next cycle alu_rs_valid_out=1, alu_rs_data_out.rob_index=1.
- Send LSU tag 2, pd 11, ps1 3 → no issue; broadcast p3 → lsu_rs_valid_out=1 the following cycle.
- Send 8 ALU instructions (tags 10–17, sources p99) → all accepted. Then valid_in=1, fu_alu=1 → ready_in=0 combinationally. A branch instruction offered instead → ready_in=1.
- Mispredict with head 10, mispredict_tag 12 → ALU entries 13–17 flushed, 10–12 kept.
- Assert reset mid-operation → all valid outputs low immediately, and ready_in=1 after release.

Source files
------------

// File: rtl/dispatch.sv
// Dispatch stage: a one-entry skid buffer feeds three age-ordered reservation
// stations, with a physical-register ready table and three CDB wakeup ports.
package dispatch_pkg;
  typedef struct packed {
    logic        fu_alu;
    logic        fu_mem;
    logic        fu_br;
    logic [6:0]  OpCode;
    logic [4:0]  rob_tag;
    logic [6:0]  pd_new;
    logic [6:0]  ps1;
    logic [6:0]  ps2;
    logic [31:0] imm;
  } rename_data;

  typedef struct packed {
    logic [4:0]  rob_index;
    logic [6:0]  OpCode;
    logic [6:0]  pd;
    logic [6:0]  ps1;
    logic [6:0]  ps2;
    logic [31:0] imm;
    logic [2:0]  fu_type;
  } rs_data;
endpackage

module dispatch_rs
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_wrEn,
  input  rs_data          i_wrData,
  input  logic            i_wrRdy1,
  input  logic            i_wrRdy2,
  input  logic [2:0]      i_cdbValid,
  input  logic [2:0][6:0] i_cdbTag,
  input  logic [4:0]      i_head,
  input  logic            i_flush,
  input  logic [4:0]      i_flushAge,
  input  logic            i_issueReady,
  output logic            o_issueValid,
  output rs_data          o_issueData,
  output logic            o_full,
  output logic            o_lastFree
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rs_data           r_ent [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_rdy1;
  logic [DEPTH-1:0] r_rdy2;
  logic [IW-1:0]    w_sel;
  logic [IW-1:0]    w_freeIdx;
  logic [CW-1:0]    w_count;
  logic [4:0]       w_age;
  logic [4:0]       w_bestAge;
  logic             w_found;

  // Oldest ready entry wins; age is distance from the ROB head, modulo 32.
  always_comb begin
    w_sel     = '0;
    w_found   = 1'b0;
    w_age     = '0;
    w_bestAge = '0;
    w_freeIdx = '0;
    w_count   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_age = r_ent[i].rob_index - i_head;
      if (r_valid[i] && r_rdy1[i] && r_rdy2[i] && (!w_found || w_age < w_bestAge)) begin
        w_found   = 1'b1;
        w_bestAge = w_age;
        w_sel     = IW'(i);
      end
      w_count = w_count + CW'(r_valid[i]);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_freeIdx = IW'(i);
    end
  end

  assign o_issueValid = w_found;
  assign o_issueData  = r_ent[w_sel];
  assign o_full       = (w_count == CW'(DEPTH));
  assign o_lastFree   = (w_count == CW'(DEPTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_rdy1  <= '0;
      r_rdy2  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int p = 0; p < 3; p++) begin
          if (i_cdbValid[p] && r_ent[i].ps1 == i_cdbTag[p]) r_rdy1[i] <= 1'b1;
          if (i_cdbValid[p] && r_ent[i].ps2 == i_cdbTag[p]) r_rdy2[i] <= 1'b1;
        end
        if ((w_found && i_issueReady && w_sel == IW'(i)) ||
            (i_flush && (r_ent[i].rob_index - i_head) > i_flushAge))
          r_valid[i] <= 1'b0;
        if (i_wrEn && w_freeIdx == IW'(i)) begin
          r_valid[i] <= 1'b1;
          r_rdy1[i]  <= i_wrRdy1;
          r_rdy2[i]  <= i_wrRdy2;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_wrEn && w_freeIdx == IW'(i)) r_ent[i] <= i_wrData;
    end
  end
endmodule

module dispatch
  import dispatch_pkg::*;
#(
  parameter int ALU_RS_DEPTH = 8,
  parameter int BR_RS_DEPTH  = 4,
  parameter int LSU_RS_DEPTH = 8,
  parameter int NUM_PREGS    = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  rename_data data_in,
  output logic       ready_in,
  output logic       alu_rs_valid_out,
  output logic       br_rs_valid_out,
  output logic       lsu_rs_valid_out,
  output rs_data     alu_rs_data_out,
  output rs_data     br_rs_data_out,
  output rs_data     lsu_rs_data_out,
  input  logic       alu_rs_ready_in,
  input  logic       br_rs_ready_in,
  input  logic       lsu_rs_ready_in,
  output logic [6:0] dispatch_nr_reg,
  output logic       dispatch_nr_valid,
  input  logic [6:0] preg1_rdy,
  input  logic [6:0] preg2_rdy,
  input  logic [6:0] preg3_rdy,
  input  logic       preg1_valid,
  input  logic       preg2_valid,
  input  logic       preg3_valid,
  input  logic       complete_in,
  input  logic [4:0] rob_fu_tag,
  input  logic       mispredict,
  input  logic [4:0] mispredict_tag,
  input  logic [4:0] rob_retire_tag,
  input  logic       rob_retire_valid
);
  logic                 r_skidValid;
  rename_data           r_skid;
  logic [NUM_PREGS-1:0] r_pregRdy;
  logic [1:0]           w_inTgt;
  logic [1:0]           w_skidTgt;
  logic [2:0]           w_full;
  logic [2:0]           w_lastFree;
  logic [2:0]           w_wrEn;
  logic [2:0]           w_cdbValid;
  logic [2:0][6:0]      w_cdbTag;
  logic [4:0]           w_mispAge;
  logic                 w_skidFlush;
  logic                 w_drain;
  logic                 w_inSpace;
  logic                 w_wrRdy1;
  logic                 w_wrRdy2;
  rs_data               w_wrData;
  logic                 w_unused;

  // RS index: 0 = ALU, 1 = LSU, 2 = branch.
  function automatic logic [1:0] routeOf(input rename_data d);
    return d.fu_alu ? 2'd0 : (d.fu_mem ? 2'd1 : 2'd2);
  endfunction

  assign w_unused    = ^{complete_in, rob_fu_tag, rob_retire_valid};
  assign w_cdbValid  = {preg3_valid, preg2_valid, preg1_valid};
  assign w_cdbTag    = {preg3_rdy, preg2_rdy, preg1_rdy};
  assign w_inTgt     = routeOf(data_in);
  assign w_skidTgt   = routeOf(r_skid);
  assign w_mispAge   = mispredict_tag - rob_retire_tag;
  assign w_skidFlush = mispredict && r_skidValid && (r_skid.rob_tag - rob_retire_tag) > w_mispAge;
  assign w_drain     = r_skidValid && !w_skidFlush && !w_full[w_skidTgt];
  assign w_inSpace   = (r_skidValid && w_skidTgt == w_inTgt) ?
                       !(w_full[w_inTgt] || w_lastFree[w_inTgt]) : !w_full[w_inTgt];
  assign ready_in    = !mispredict && (!r_skidValid || w_drain) && (!valid_in || w_inSpace);

  assign w_wrEn   = {w_drain && w_skidTgt == 2'd2, w_drain && w_skidTgt == 2'd1,
                     w_drain && w_skidTgt == 2'd0};
  assign w_wrData = '{rob_index: r_skid.rob_tag, OpCode: r_skid.OpCode, pd: r_skid.pd_new,
                      ps1: r_skid.ps1, ps2: r_skid.ps2, imm: r_skid.imm,
                      fu_type: {r_skid.fu_alu, r_skid.fu_mem, r_skid.fu_br}};

  // A source broadcast on the same edge as the RS write must not be lost.
  always_comb begin
    w_wrRdy1 = r_pregRdy[r_skid.ps1];
    w_wrRdy2 = r_pregRdy[r_skid.ps2];
    for (int p = 0; p < 3; p++) begin
      if (w_cdbValid[p] && w_cdbTag[p] == r_skid.ps1) w_wrRdy1 = 1'b1;
      if (w_cdbValid[p] && w_cdbTag[p] == r_skid.ps2) w_wrRdy2 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skidValid <= 1'b0;
      r_skid      <= '0;
    end else if (valid_in && ready_in) begin
      r_skidValid <= 1'b1;
      r_skid      <= data_in;
    end else if (w_drain || w_skidFlush) begin
      r_skidValid <= 1'b0;
    end
  end

  // CDB sets are written last so they override a same-edge busy marking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pregRdy <= NUM_PREGS'(1);
    end else begin
      if (w_drain && r_skid.pd_new != 7'd0) r_pregRdy[r_skid.pd_new] <= 1'b0;
      for (int p = 0; p < 3; p++) begin
        if (w_cdbValid[p]) r_pregRdy[w_cdbTag[p]] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dispatch_nr_valid <= 1'b0;
      dispatch_nr_reg   <= '0;
    end else if (w_drain) begin
      dispatch_nr_valid <= 1'b1;
      dispatch_nr_reg   <= r_skid.pd_new;
    end
  end

  dispatch_rs #(.DEPTH(ALU_RS_DEPTH)) u_aluRs (
    .clk(clk), .reset(reset), .i_wrEn(w_wrEn[0]), .i_wrData(w_wrData),
    .i_wrRdy1(w_wrRdy1), .i_wrRdy2(w_wrRdy2), .i_cdbValid(w_cdbValid), .i_cdbTag(w_cdbTag),
    .i_head(rob_retire_tag), .i_flush(mispredict), .i_flushAge(w_mispAge),
    .i_issueReady(alu_rs_ready_in), .o_issueValid(alu_rs_valid_out),
    .o_issueData(alu_rs_data_out), .o_full(w_full[0]), .o_lastFree(w_lastFree[0]));

  dispatch_rs #(.DEPTH(LSU_RS_DEPTH)) u_lsuRs (
    .clk(clk), .reset(reset), .i_wrEn(w_wrEn[1]), .i_wrData(w_wrData),
    .i_wrRdy1(w_wrRdy1), .i_wrRdy2(w_wrRdy2), .i_cdbValid(w_cdbValid), .i_cdbTag(w_cdbTag),
    .i_head(rob_retire_tag), .i_flush(mispredict), .i_flushAge(w_mispAge),
    .i_issueReady(lsu_rs_ready_in), .o_issueValid(lsu_rs_valid_out),
    .o_issueData(lsu_rs_data_out), .o_full(w_full[1]), .o_lastFree(w_lastFree[1]));

  dispatch_rs #(.DEPTH(BR_RS_DEPTH)) u_brRs (
    .clk(clk), .reset(reset), .i_wrEn(w_wrEn[2]), .i_wrData(w_wrData),
    .i_wrRdy1(w_wrRdy1), .i_wrRdy2(w_wrRdy2), .i_cdbValid(w_cdbValid), .i_cdbTag(w_cdbTag),
    .i_head(rob_retire_tag), .i_flush(mispredict), .i_flushAge(w_mispAge),
    .i_issueReady(br_rs_ready_in), .o_issueValid(br_rs_valid_out),
    .o_issueData(br_rs_data_out), .o_full(w_full[2]), .o_lastFree(w_lastFree[2]));
endmodule

// File: tb/tb_dispatch.sv
// Self-checking bench for dispatch: directed scenarios, then randomized traffic
// compared every cycle against a queue-based model of the dispatch rules.
module tb_dispatch;
  import dispatch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic valid_in, ready_in;
  rename_data data_in;
  logic alu_rs_valid_out, br_rs_valid_out, lsu_rs_valid_out;
  rs_data alu_rs_data_out, br_rs_data_out, lsu_rs_data_out;
  logic alu_rs_ready_in, br_rs_ready_in, lsu_rs_ready_in;
  logic [6:0] dispatch_nr_reg;
  logic dispatch_nr_valid;
  logic [6:0] preg1_rdy, preg2_rdy, preg3_rdy;
  logic preg1_valid, preg2_valid, preg3_valid;
  logic complete_in;
  logic [4:0] rob_fu_tag;
  logic mispredict;
  logic [4:0] mispredict_tag, rob_retire_tag;
  logic rob_retire_valid;

  always #5 clk = ~clk;

  dispatch dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in),
    .alu_rs_valid_out(alu_rs_valid_out), .br_rs_valid_out(br_rs_valid_out),
    .lsu_rs_valid_out(lsu_rs_valid_out), .alu_rs_data_out(alu_rs_data_out),
    .br_rs_data_out(br_rs_data_out), .lsu_rs_data_out(lsu_rs_data_out),
    .alu_rs_ready_in(alu_rs_ready_in), .br_rs_ready_in(br_rs_ready_in),
    .lsu_rs_ready_in(lsu_rs_ready_in), .dispatch_nr_reg(dispatch_nr_reg),
    .dispatch_nr_valid(dispatch_nr_valid), .preg1_rdy(preg1_rdy), .preg2_rdy(preg2_rdy),
    .preg3_rdy(preg3_rdy), .preg1_valid(preg1_valid), .preg2_valid(preg2_valid),
    .preg3_valid(preg3_valid), .complete_in(complete_in), .rob_fu_tag(rob_fu_tag),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .rob_retire_tag(rob_retire_tag), .rob_retire_valid(rob_retire_valid));

  int checks = 0;
  int errors = 0;

  // Model state: one unordered queue per RS (0 ALU, 1 LSU, 2 branch).
  typedef struct {
    rs_data d;
    bit     r1;
    bit     r2;
  } mEnt_t;
  mEnt_t      mRs [3][$];
  int         depthOf [3] = '{8, 8, 4};
  string      rsName [3] = '{"alu", "lsu", "br"};
  bit         mReady [128];
  bit         mSkidV;
  rename_data mSkid;
  bit         mNrV;
  bit [6:0]   mNrReg;
  bit         mAccepted;

  bit eReady, eDrain, eSkidFlush;
  bit eIssueV [3];
  int eIssueIdx [3];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [4:0] ageOf(input bit [4:0] t);
    return t - rob_retire_tag;
  endfunction

  function automatic int routeOf(input rename_data d);
    if (d.fu_alu) return 0;
    if (d.fu_mem) return 1;
    return 2;
  endfunction

  function automatic bit cdbHit(input bit [6:0] t);
    return (preg1_valid && preg1_rdy == t) || (preg2_valid && preg2_rdy == t) ||
           (preg3_valid && preg3_rdy == t);
  endfunction

  function automatic logic dutValid(input int k);
    return (k == 0) ? alu_rs_valid_out : (k == 1) ? lsu_rs_valid_out : br_rs_valid_out;
  endfunction

  function automatic rs_data dutData(input int k);
    return (k == 0) ? alu_rs_data_out : (k == 1) ? lsu_rs_data_out : br_rs_data_out;
  endfunction

  function automatic logic fuReady(input int k);
    return (k == 0) ? alu_rs_ready_in : (k == 1) ? lsu_rs_ready_in : br_rs_ready_in;
  endfunction

  function automatic bit tagLive(input bit [4:0] t);
    if (mSkidV && mSkid.rob_tag == t) return 1'b1;
    for (int k = 0; k < 3; k++)
      foreach (mRs[k][j]) if (mRs[k][j].d.rob_index == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) mRs[k].delete();
    foreach (mReady[i]) mReady[i] = 1'b0;
    mReady[0] = 1'b1;
    mSkidV = 1'b0;
    mSkid  = '0;
    mNrV   = 1'b0;
    mNrReg = '0;
  endtask

  task automatic computeExpected();
    int occ, best;
    int tgt;
    eSkidFlush = mispredict && mSkidV && ageOf(mSkid.rob_tag) > ageOf(mispredict_tag);
    tgt = routeOf(mSkid);
    eDrain = mSkidV && !eSkidFlush && mRs[tgt].size() < depthOf[tgt];
    tgt = routeOf(data_in);
    occ = mRs[tgt].size() + ((mSkidV && routeOf(mSkid) == tgt) ? 1 : 0);
    eReady = !mispredict && (!mSkidV || eDrain) && (!valid_in || occ < depthOf[tgt]);
    for (int k = 0; k < 3; k++) begin
      best = -1;
      foreach (mRs[k][j]) begin
        if (mRs[k][j].r1 && mRs[k][j].r2 &&
            (best < 0 || ageOf(mRs[k][j].d.rob_index) < ageOf(mRs[k][best].d.rob_index)))
          best = j;
      end
      eIssueIdx[k] = best;
      eIssueV[k]   = (best >= 0);
    end
  endtask

  task automatic compareAll();
    computeExpected();
    checkOutput("ready_in", ready_in, eReady);
    for (int k = 0; k < 3; k++) begin
      checkOutput({rsName[k], "_valid"}, dutValid(k), eIssueV[k]);
      if (eIssueV[k]) checkOutput({rsName[k], "_data"}, dutData(k), mRs[k][eIssueIdx[k]].d);
    end
    checkOutput("nr_valid", dispatch_nr_valid, mNrV);
    checkOutput("nr_reg", dispatch_nr_reg, mNrReg);
  endtask

  task automatic modelEdge();
    mEnt_t keep [$];
    mEnt_t e;
    computeExpected();
    mAccepted = valid_in && eReady;
    for (int k = 0; k < 3; k++) begin
      keep.delete();
      foreach (mRs[k][j]) begin
        e = mRs[k][j];
        if (eIssueV[k] && fuReady(k) && j == eIssueIdx[k]) continue;
        if (mispredict && ageOf(e.d.rob_index) > ageOf(mispredict_tag)) continue;
        if (cdbHit(e.d.ps1)) e.r1 = 1'b1;
        if (cdbHit(e.d.ps2)) e.r2 = 1'b1;
        keep.push_back(e);
      end
      if (eDrain && routeOf(mSkid) == k) begin
        e.d = '{rob_index: mSkid.rob_tag, OpCode: mSkid.OpCode, pd: mSkid.pd_new,
                ps1: mSkid.ps1, ps2: mSkid.ps2, imm: mSkid.imm,
                fu_type: {mSkid.fu_alu, mSkid.fu_mem, mSkid.fu_br}};
        e.r1 = mReady[mSkid.ps1] || cdbHit(mSkid.ps1);
        e.r2 = mReady[mSkid.ps2] || cdbHit(mSkid.ps2);
        keep.push_back(e);
      end
      mRs[k] = keep;
    end
    if (eDrain) begin
      if (mSkid.pd_new != 0) mReady[mSkid.pd_new] = 1'b0;
      mNrV   = 1'b1;
      mNrReg = mSkid.pd_new;
    end
    if (preg1_valid) mReady[preg1_rdy] = 1'b1;
    if (preg2_valid) mReady[preg2_rdy] = 1'b1;
    if (preg3_valid) mReady[preg3_rdy] = 1'b1;
    if (mAccepted) begin
      mSkidV = 1'b1;
      mSkid  = data_in;
    end else if (eDrain || eSkidFlush) begin
      mSkidV = 1'b0;
    end
  endtask

  task automatic step();
    #1 compareAll();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    valid_in = 1'b0;
    data_in  = '0;
    {preg1_valid, preg2_valid, preg3_valid} = '0;
    {preg1_rdy, preg2_rdy, preg3_rdy} = '0;
    mispredict = 1'b0;
    mispredict_tag = '0;
  endtask

  // fu: 0 ALU, 1 LSU, 2 branch
  task automatic applyStimulus(input bit v, input int fu, input bit [4:0] tag,
                               input bit [6:0] pd, input bit [6:0] s1, input bit [6:0] s2);
    valid_in = v;
    data_in = '0;
    data_in.fu_alu  = (fu == 0);
    data_in.fu_mem  = (fu == 1);
    data_in.fu_br   = (fu == 2);
    data_in.OpCode  = 7'(tag + 7'd3);
    data_in.rob_tag = tag;
    data_in.pd_new  = pd;
    data_in.ps1     = s1;
    data_in.ps2     = s2;
    data_in.imm     = {27'h0, tag} ^ 32'hA5A5_0000;
  endtask

  int issued [$];
  bit [4:0] nextTag;

  initial begin
    reset = 1'b0;
    idleInputs();
    {alu_rs_ready_in, br_rs_ready_in, lsu_rs_ready_in} = 3'b111;
    complete_in = 1'b0; rob_fu_tag = '0;
    rob_retire_tag = '0; rob_retire_valid = 1'b1;
    modelReset();
    repeat (2) @(negedge clk);
    #1 checkOutput("reset_alu_valid", alu_rs_valid_out, 1'b0);
    checkOutput("reset_nr_valid", dispatch_nr_valid, 1'b0);
    checkOutput("reset_nr_reg", dispatch_nr_reg, 7'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 checkOutput("after_reset_ready_in", ready_in, 1'b1);
    step();

    // ALU op waiting on p1/p2
    applyStimulus(1, 0, 5'd1, 7'd10, 7'd1, 7'd2);
    step();
    idleInputs();
    step();
    #1 checkOutput("t1_nr_valid", dispatch_nr_valid, 1'b1);
    checkOutput("t1_nr_reg", dispatch_nr_reg, 7'd10);
    checkOutput("t1_alu_valid", alu_rs_valid_out, 1'b0);
    preg1_valid = 1'b1; preg1_rdy = 7'd1;
    preg2_valid = 1'b1; preg2_rdy = 7'd2;
    step();
    idleInputs();
    #1 checkOutput("t2_alu_valid", alu_rs_valid_out, 1'b1);
    checkOutput("t2_alu_rob", alu_rs_data_out.rob_index, 5'd1);
    step();

    // LSU op waiting on p3; ps2 = p0 is ready
    applyStimulus(1, 1, 5'd2, 7'd11, 7'd3, 7'd0);
    step();
    idleInputs();
    step();
    #1 checkOutput("t3_lsu_wait", lsu_rs_valid_out, 1'b0);
    preg1_valid = 1'b1; preg1_rdy = 7'd3;
    step();
    idleInputs();
    #1 checkOutput("t3_lsu_valid", lsu_rs_valid_out, 1'b1);
    checkOutput("t3_lsu_rob", lsu_rs_data_out.rob_index, 5'd2);
    step();

    // Fill the ALU RS with tags 10..17
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 5'(10 + i), 7'(20 + i), 7'd99, 7'd99);
      #1 checkOutput("fill_ready_in", ready_in, 1'b1);
      step();
    end
    applyStimulus(1, 0, 5'd18, 7'd40, 7'd0, 7'd0);
    #1 checkOutput("alu_full_ready_in", ready_in, 1'b0);
    applyStimulus(1, 2, 5'd18, 7'd30, 7'd0, 7'd0);
    #1 checkOutput("br_while_alu_full", ready_in, 1'b1);
    step();
    idleInputs();
    step();

    rob_retire_tag = 5'd10;
    mispredict = 1'b1; mispredict_tag = 5'd12;
    #1 checkOutput("misp_ready_in", ready_in, 1'b0);
    step();
    idleInputs();
    preg3_valid = 1'b1; preg3_rdy = 7'd99;
    step();
    idleInputs();
    for (int i = 0; i < 5; i++) begin
      #1 if (alu_rs_valid_out) issued.push_back(int'(alu_rs_data_out.rob_index));
      step();
    end
    checkOutput("flush_survivors", issued.size(), 3);
    if (issued.size() == 3) begin
      checkOutput("flush_first", issued[0], 10);
      checkOutput("flush_second", issued[1], 11);
      checkOutput("flush_third", issued[2], 12);
    end

    // Randomized traffic
    nextTag = 5'd19;
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        #3 reset = 1'b0;
        #1 checkOutput("midreset_alu_valid", alu_rs_valid_out, 1'b0);
        checkOutput("midreset_lsu_valid", lsu_rs_valid_out, 1'b0);
        checkOutput("midreset_br_valid", br_rs_valid_out, 1'b0);
        checkOutput("midreset_nr_valid", dispatch_nr_valid, 1'b0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        idleInputs();
        #1 checkOutput("midreset_ready_in", ready_in, 1'b1);
        @(negedge clk);
      end
      idleInputs();
      applyStimulus(($urandom_range(9) < 7) && !tagLive(nextTag), $urandom_range(2), nextTag,
                    7'($urandom_range(15)), 7'($urandom_range(15)), 7'($urandom_range(15)));
      data_in.OpCode = 7'($urandom);
      data_in.imm    = $urandom;
      preg1_valid = ($urandom_range(9) < 3); preg1_rdy = 7'($urandom_range(15));
      preg2_valid = ($urandom_range(9) < 3); preg2_rdy = 7'($urandom_range(15));
      preg3_valid = ($urandom_range(9) < 3); preg3_rdy = 7'($urandom_range(15));
      mispredict = ($urandom_range(99) < 3);
      mispredict_tag = 5'($urandom);
      rob_retire_tag = nextTag + 5'd1;
      alu_rs_ready_in = ($urandom_range(9) < 7);
      lsu_rs_ready_in = ($urandom_range(9) < 7);
      br_rs_ready_in  = ($urandom_range(9) < 7);
      step();
      if (mAccepted) nextTag = nextTag + 5'd1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
